credit_duplex_xbar: RTL
=======================

# credit_duplex_xbar

Full-duplex initiator/target crossbar that caps in-flight requests per initiator and decouples responses through per-target FIFOs. Request path: combinational, round-robin per target, grant locked until handshake so the valid/ready contract holds. Response path: registered FIFO stage per target, then lock-stable round-robin per initiator. Drop-in successor to the unbounded variable-latency crossbar wherever targets must not be flooded and responses may back-pressure.

## Interface
- NumIn, 4, number of initiators (≥1)
- NumOut, 4, number of targets (≥1)
- ReqDataWidth, 32, request payload width
- RespDataWidth, 32, response payload width
- MaxOutstanding, 4, in-flight request cap per initiator (≥1)
- RespFifoDepth, 2, response FIFO entries per target (≥1)
- Clocking: one clock; reset is synchronous and active-high.
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  NumIn  initiator request valid
- req_ready_o  out  NumIn  initiator request ready
- req_tgt_addr_i  in  NumIn×clog2(NumOut)  target index
- req_wdata_i  in  NumIn×ReqDataWidth  request payload
- resp_valid_o  out  NumIn  response valid
- resp_ready_i  in  NumIn  response ready
- resp_rdata_o  out  NumIn×RespDataWidth  response payload
- resp_err_o  out  NumIn  one-cycle pulse: response accepted for initiator with zero outstanding
- req_valid_o  out  NumOut  target request valid
- req_ready_i  in  NumOut  target request ready
- req_ini_addr_o  out  NumOut×clog2(NumIn)  granted initiator index
- req_wdata_o  out  NumOut×ReqDataWidth  request payload
- resp_valid_i  in  NumOut  target response valid
- resp_ready_o  out  NumOut  target response ready (= FIFO not full)
- resp_ini_addr_i  in  NumOut×clog2(NumIn)  destination initiator
- resp_rdata_i  in  NumOut×RespDataWidth  response payload

## Operation
- Eligibility: initiator i eligible for target t iff req_valid_i[i], req_tgt_addr_i[i]==t, outst[i] < MaxOutstanding.
- Request arbiter per target: if unlocked, grant first eligible at or after rr_ptr[t] (wrap NumIn-1→0); drives req_valid_o/ini_addr/wdata. Grant without handshake → lock on that initiator. Handshake → unlock, rr_ptr[t] = granted+1 mod NumIn.
- req_ready_o[i] = granted by its target AND req_ready_i of that target.
- Outstanding counter outst[i], width clog2(MaxOutstanding+1): +1 on request handshake, −1 on response handshake at initiator, both same cycle → unchanged. At 0, response handshake leaves 0 and pulses resp_err_o[i]. At MaxOutstanding, req_ready_o[i]=0.
- Response FIFO per target: push on resp_valid_i & resp_ready_o, stores {ini_addr, rdata}; no fall-through. Push and pop same cycle when full allowed only if pop — resp_ready_o stays !full (registered full; no pop-bypass).
- Response arbiter per initiator: candidates are non-empty FIFO heads addressed to it; same round-robin + lock scheme over NumOut, pointer rr_resp[i]. Handshake pops the granted FIFO.
- NumIn==1 or NumOut==1: index widths forced to 1, index outputs 0.

## Timing
- Request path: zero latency, purely combinational initiator→target.
- Response path: ≥1 cycle; resp_valid_o earliest cycle after push.
- Locked grant: req_valid_o, ini_addr, wdata stable until handshake even if other initiators raise valid. Initiator dropping valid while locked is a protocol violation (assertion).
- Reset (rst_i high at clock edge): outst=0, rr pointers=0, locks clear, FIFOs empty. While rst_i high, all valid/ready outputs forced 0, resp_err_o=0; data outputs don't-care. Reset mid-burst discards FIFO contents and in-flight counts.

## Structure
- Package credit_xbar_pkg: width helper functions (idx width with 1-minimum), lock-state typedef.
- Sub-module rr_lock_arbiter (NumReq, DataWidth): round-robin with grant lock and pointer update; instantiated NumOut times on request side, NumIn times on response side.
- FIFO: existing codebase FIFO, fall-through off.

## Test plan (NumIn=4, NumOut=4, MaxOutstanding=2, RespFifoDepth=2)
- All 4 initiators to target 2, req_ready_i[2]=1 → grants 0,1,2,3 on consecutive cycles, ini_addr_o 0..3.
- Initiator 1 to target 0, req_ready_i[0]=0 for 3 cycles, initiator 0 raises valid in cycle 2 → ini_addr_o holds 1 until ready, then 0 next.
- Initiator 3 issues 2 requests, no responses → req_ready_o[3]=0 on 3rd; response to 3 accepted → ready returns next cycle.
- Targets 0 and 1 respond to initiator 2 same cycle, resp_ready_i[2]=1 → target 0 data then target 1 data, 1 cycle apart; resp_ready_o stays 1.
- resp_ready_i[0]=0, target 1 pushes 3 responses to initiator 0 → resp_ready_o[1]=0 after 2 pushes; 3rd held on target side.
- Response to initiator with outst=0 → resp_err_o pulse 1 cycle; rst_i mid-traffic → all valids 0, counters 0 next cycle.

Source files
------------

// File: rtl/credit_xbar_pkg.sv
// Shared width helpers and arbiter lock state for the credit-limited duplex crossbar.
package credit_xbar_pkg;

  // Index width, at least 1 bit so single-port configurations still have a port.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

  typedef enum logic {LockIdle, LockHeld} lock_e;

endpackage

// File: rtl/credit_duplex_xbar_if.sv
// Initiator- and target-side bundles of the duplex crossbar.
interface credit_duplex_xbar_if #(
  parameter int unsigned NumIn         = 4,
  parameter int unsigned NumOut        = 4,
  parameter int unsigned ReqDataWidth  = 32,
  parameter int unsigned RespDataWidth = 32
);
  localparam int unsigned InW  = credit_xbar_pkg::idx_w(NumIn);
  localparam int unsigned OutW = credit_xbar_pkg::idx_w(NumOut);

  logic [NumIn-1:0]                     req_valid_i;
  logic [NumIn-1:0]                     req_ready_o;
  logic [NumIn-1:0][OutW-1:0]           req_tgt_addr_i;
  logic [NumIn-1:0][ReqDataWidth-1:0]   req_wdata_i;
  logic [NumIn-1:0]                     resp_valid_o;
  logic [NumIn-1:0]                     resp_ready_i;
  logic [NumIn-1:0][RespDataWidth-1:0]  resp_rdata_o;
  logic [NumIn-1:0]                     resp_err_o;

  logic [NumOut-1:0]                    req_valid_o;
  logic [NumOut-1:0]                    req_ready_i;
  logic [NumOut-1:0][InW-1:0]           req_ini_addr_o;
  logic [NumOut-1:0][ReqDataWidth-1:0]  req_wdata_o;
  logic [NumOut-1:0]                    resp_valid_i;
  logic [NumOut-1:0]                    resp_ready_o;
  logic [NumOut-1:0][InW-1:0]           resp_ini_addr_i;
  logic [NumOut-1:0][RespDataWidth-1:0] resp_rdata_i;

  modport slave (
    input  req_valid_i, req_tgt_addr_i, req_wdata_i, resp_ready_i,
    input  req_ready_i, resp_valid_i, resp_ini_addr_i, resp_rdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    output req_valid_o, req_ini_addr_o, req_wdata_o, resp_ready_o
  );

  modport master (
    output req_valid_i, req_tgt_addr_i, req_wdata_i, resp_ready_i,
    output req_ready_i, resp_valid_i, resp_ini_addr_i, resp_rdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    input  req_valid_o, req_ini_addr_o, req_wdata_o, resp_ready_o
  );

endinterface

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter whose grant stays locked on one requester until the handshake completes.
module rr_lock_arbiter import credit_xbar_pkg::*; #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned DataWidth = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumReq-1:0]                 req_i,
  input  logic [NumReq-1:0][DataWidth-1:0]  data_i,
  input  logic                              ready_i,
  output logic                              valid_o,
  output logic [idx_w(NumReq)-1:0]          idx_o,
  output logic [DataWidth-1:0]              data_o
);
  localparam int unsigned IdxW = idx_w(NumReq);

  lock_e           state_q, state_d;
  logic [IdxW-1:0] lock_q, lock_d, ptr_q, ptr_d, pick, gnt, cand;
  logic            found;

  function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] x);
    return IdxW'((32'(x) + 32'd1) % NumReq);
  endfunction

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NumReq; k++) begin
      cand = IdxW'((32'(ptr_q) + 32'(k)) % NumReq);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign gnt     = (state_q == LockHeld) ? lock_q : pick;
  assign valid_o = !rst_i && ((state_q == LockHeld) || found);
  assign idx_o   = gnt;
  assign data_o  = data_i[gnt];

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    ptr_d   = ptr_q;
    case (state_q)
      LockIdle: begin
        if (found) begin
          if (ready_i) begin
            ptr_d = wrap_inc(pick);
          end else begin
            state_d = LockHeld;
            lock_d  = pick;
          end
        end
      end
      LockHeld: begin
        if (ready_i) begin
          state_d = LockIdle;
          ptr_d   = wrap_inc(lock_q);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= LockIdle;
      lock_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      ptr_q   <= ptr_d;
    end
  end

  // A locked requester must keep asserting its request until served.
  held_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == LockHeld) |-> req_i[lock_q]);

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO without fall-through; full/empty come from registered occupancy only.
module sync_fifo import credit_xbar_pkg::*; #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] din_i,
  input  logic             pop_i,
  output logic [Width-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PtrW = idx_w(Depth);
  localparam int unsigned CntW = cnt_w(Depth);

  logic [Depth-1:0][Width-1:0] mem_q;
  logic [PtrW-1:0]             wr_q, rd_q;
  logic [CntW-1:0]             cnt_q;
  logic                        do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (32'(cnt_q) == Depth);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= ptr_inc(wr_q);
      if (do_pop)  rd_q <= ptr_inc(rd_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CntW'(1);
      else if (!do_push && do_pop) cnt_q <= cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/credit_duplex_xbar.sv
// Credit-capped request crossbar with per-target response FIFOs and per-initiator response
// arbitration. resp_err_o pulses in the cycle a response is accepted by an idle initiator.
module credit_duplex_xbar import credit_xbar_pkg::*; #(
  parameter int unsigned NumIn          = 4,
  parameter int unsigned NumOut         = 4,
  parameter int unsigned ReqDataWidth   = 32,
  parameter int unsigned RespDataWidth  = 32,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned RespFifoDepth  = 2
) (
  input logic                 clk_i,
  input logic                 rst_i,
  credit_duplex_xbar_if.slave bus
);
  localparam int unsigned InW  = idx_w(NumIn);
  localparam int unsigned OutW = idx_w(NumOut);
  localparam int unsigned CntW = cnt_w(MaxOutstanding);
  localparam int unsigned EntW = InW + RespDataWidth;

  logic [NumIn-1:0][CntW-1:0]           outst_q, outst_d;
  logic [NumIn-1:0]                     below_cap, ini_ready, req_hs, resp_hs, resp_err;
  logic [NumOut-1:0][NumIn-1:0]         elig;
  logic [NumOut-1:0]                    tgt_valid;
  logic [NumOut-1:0][InW-1:0]           tgt_ini;
  logic [NumOut-1:0][ReqDataWidth-1:0]  tgt_wdata;

  logic [NumOut-1:0]                    fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [NumOut-1:0][EntW-1:0]          fifo_head;
  logic [NumOut-1:0][InW-1:0]           head_ini;
  logic [NumOut-1:0][RespDataWidth-1:0] head_data;
  logic [NumIn-1:0][NumOut-1:0]         cand;
  logic [NumIn-1:0]                     ini_valid;
  logic [NumIn-1:0][OutW-1:0]           ini_src;
  logic [NumIn-1:0][RespDataWidth-1:0]  ini_rdata;

  always_comb begin
    for (int i = 0; i < NumIn; i++) begin
      below_cap[i] = (32'(outst_q[i]) < MaxOutstanding);
    end
    for (int t = 0; t < NumOut; t++) begin
      for (int i = 0; i < NumIn; i++) begin
        elig[t][i] = bus.req_valid_i[i] && (bus.req_tgt_addr_i[i] == OutW'(t)) && below_cap[i];
      end
    end
  end

  for (genvar t = 0; t < NumOut; t++) begin : g_tgt
    rr_lock_arbiter #(
      .NumReq    (NumIn),
      .DataWidth (ReqDataWidth)
    ) u_req_arb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req_i   (elig[t]),
      .data_i  (bus.req_wdata_i),
      .ready_i (bus.req_ready_i[t]),
      .valid_o (tgt_valid[t]),
      .idx_o   (tgt_ini[t]),
      .data_o  (tgt_wdata[t])
    );

    sync_fifo #(
      .Width (EntW),
      .Depth (RespFifoDepth)
    ) u_resp_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push[t]),
      .din_i   ({bus.resp_ini_addr_i[t], bus.resp_rdata_i[t]}),
      .pop_i   (fifo_pop[t]),
      .dout_o  (fifo_head[t]),
      .full_o  (fifo_full[t]),
      .empty_o (fifo_empty[t])
    );

    assign fifo_push[t] = bus.resp_valid_i[t] & ~fifo_full[t] & ~rst_i;
    assign head_ini[t]  = fifo_head[t][EntW-1:RespDataWidth];
    assign head_data[t] = fifo_head[t][RespDataWidth-1:0];
  end

  always_comb begin
    ini_ready = '0;
    for (int i = 0; i < NumIn; i++) begin
      for (int t = 0; t < NumOut; t++) begin
        if (tgt_valid[t] && bus.req_ready_i[t] && (tgt_ini[t] == InW'(i))) ini_ready[i] = 1'b1;
      end
      ini_ready[i] = ini_ready[i] & below_cap[i];
    end
  end

  assign req_hs = bus.req_valid_i & ini_ready;

  always_comb begin
    for (int i = 0; i < NumIn; i++) begin
      for (int t = 0; t < NumOut; t++) begin
        cand[i][t] = !fifo_empty[t] && (head_ini[t] == InW'(i));
      end
    end
  end

  for (genvar i = 0; i < NumIn; i++) begin : g_ini
    rr_lock_arbiter #(
      .NumReq    (NumOut),
      .DataWidth (RespDataWidth)
    ) u_resp_arb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req_i   (cand[i]),
      .data_i  (head_data),
      .ready_i (bus.resp_ready_i[i]),
      .valid_o (ini_valid[i]),
      .idx_o   (ini_src[i]),
      .data_o  (ini_rdata[i])
    );
  end

  assign resp_hs = ini_valid & bus.resp_ready_i;

  always_comb begin
    fifo_pop = '0;
    for (int t = 0; t < NumOut; t++) begin
      for (int i = 0; i < NumIn; i++) begin
        if (resp_hs[i] && (ini_src[i] == OutW'(t))) fifo_pop[t] = 1'b1;
      end
    end
  end

  // Counter saturates at zero; a stray response only raises the error pulse.
  always_comb begin
    for (int i = 0; i < NumIn; i++) begin
      outst_d[i]  = outst_q[i];
      resp_err[i] = resp_hs[i] && (outst_q[i] == '0);
      if (req_hs[i] && !resp_hs[i]) begin
        outst_d[i] = outst_q[i] + CntW'(1);
      end else if (!req_hs[i] && resp_hs[i] && (outst_q[i] != '0)) begin
        outst_d[i] = outst_q[i] - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) outst_q <= '0;
    else       outst_q <= outst_d;
  end

  assign bus.req_valid_o    = tgt_valid;
  assign bus.req_ini_addr_o = tgt_ini;
  assign bus.req_wdata_o    = tgt_wdata;
  assign bus.req_ready_o    = ini_ready;
  assign bus.resp_valid_o   = ini_valid;
  assign bus.resp_rdata_o   = ini_rdata;
  assign bus.resp_err_o     = resp_err;
  assign bus.resp_ready_o   = ~fifo_full & {NumOut{~rst_i}};

endmodule
